// File: rtl/float_addsub_pipe.sv
// ============================================================================
// Module   : float_addsub_pipe
// Purpose  : Pipelined floating-point adder/subtractor with a valid/ready
//            handshake. It has an input register and three processing
//            stages: unpack/align, add/normalise, and round/pack.
//            Define FLOAT_ADDSUB_FLAGS_EN to add the Flags output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module float_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic [EXP_W+MAN_W:0]   Op1,
    input  logic [EXP_W+MAN_W:0]   Op2,
    input  logic                   Sub,
    input  logic [TAG_W-1:0]       InTag,
    input  logic                   InputValid,
    output logic                   InputReady,
    output logic [EXP_W+MAN_W:0]   Result,
    output logic [TAG_W-1:0]       ResultTag,
    output logic                   ResultValid,
`ifdef FLOAT_ADDSUB_FLAGS_EN
    output logic [3:0]             Flags,
`endif
    input  logic                   ResultReady
);

    localparam int C_W   = 1 + EXP_W + MAN_W;
    localparam int C_SW  = MAN_W + 4;                 // hidden + frac + G/R/S
    localparam int C_LZW = $clog2(C_SW + 1);
    localparam int C_EW  = EXP_W + C_LZW + 1;         // signed working exponent

    localparam logic [EXP_W-1:0] C_EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] C_SHIFT_LIM = EXP_W'(MAN_W + 3);
    localparam logic [C_EW-1:0]  C_EXP_MAX   = {{(C_EW-EXP_W){1'b0}}, C_EXP_ONES};
    localparam logic [C_W-1:0]   C_QNAN      = {1'b0, C_EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic [C_LZW-1:0] lzc(input logic [C_SW-1:0] v);
        logic [C_LZW-1:0] n;
        logic             found;
        n     = C_LZW'(C_SW);
        found = 1'b0;
        for (int i = C_SW - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = C_LZW'(C_SW - 1 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction

    logic w_stall;
    assign w_stall    = ResultValid && !ResultReady;
    assign InputReady = !w_stall;

    // Input register
    logic                r_v0, r_sub0;
    logic [C_W-1:0]      r_op1, r_op2;
    logic [TAG_W-1:0]    r_tag0;

    // Stage 1: unpack / classify / swap / align
    logic                w_x_sign, w_y_sign;
    logic [EXP_W-1:0]    w_x_exp, w_y_exp;
    logic [MAN_W-1:0]    w_x_frac, w_y_frac;
    logic                w_x_zero, w_y_zero, w_x_inf, w_y_inf, w_x_nan, w_y_nan;
    logic [C_W-2:0]      w_x_mag, w_y_mag;
    logic                w_swap, w_big_sign, w_small_sign, w_small_zero;
    logic [EXP_W-1:0]    w_big_exp, w_small_exp, w_diff;
    logic [MAN_W-1:0]    w_big_frac, w_small_frac;
    logic [C_SW-1:0]     w_sig_big, w_sig_small, w_shifted, w_aligned;
    logic                w_lost, w_spec;
    logic [C_W-1:0]      w_spec_res;

    assign w_x_sign = r_op1[C_W-1];
    assign w_x_exp  = r_op1[C_W-2:MAN_W];
    assign w_x_frac = r_op1[MAN_W-1:0];
    assign w_y_sign = r_op2[C_W-1] ^ r_sub0;
    assign w_y_exp  = r_op2[C_W-2:MAN_W];
    assign w_y_frac = r_op2[MAN_W-1:0];

    assign w_x_zero = (w_x_exp == '0);
    assign w_y_zero = (w_y_exp == '0);
    assign w_x_inf  = (w_x_exp == C_EXP_ONES) && (w_x_frac == '0);
    assign w_y_inf  = (w_y_exp == C_EXP_ONES) && (w_y_frac == '0);
    assign w_x_nan  = (w_x_exp == C_EXP_ONES) && (w_x_frac != '0);
    assign w_y_nan  = (w_y_exp == C_EXP_ONES) && (w_y_frac != '0);
    assign w_x_mag  = w_x_zero ? '0 : r_op1[C_W-2:0];
    assign w_y_mag  = w_y_zero ? '0 : r_op2[C_W-2:0];
    assign w_swap   = (w_y_mag > w_x_mag);

    always_comb begin
        w_big_sign   = w_swap ? w_y_sign : w_x_sign;
        w_small_sign = w_swap ? w_x_sign : w_y_sign;
        w_big_exp    = w_swap ? w_y_exp  : w_x_exp;
        w_small_exp  = w_swap ? w_x_exp  : w_y_exp;
        w_big_frac   = w_swap ? w_y_frac : w_x_frac;
        w_small_frac = w_swap ? w_x_frac : w_y_frac;
        w_small_zero = w_swap ? w_x_zero : w_y_zero;
        w_diff       = w_big_exp - w_small_exp;
        w_sig_big    = {1'b1, w_big_frac, 3'b000};
        w_sig_small  = w_small_zero ? '0 : {1'b1, w_small_frac, 3'b000};
        w_shifted    = w_sig_small >> w_diff;
        w_lost       = |(w_sig_small & ~({C_SW{1'b1}} << w_diff));
        if (w_diff >= C_SHIFT_LIM) begin
            w_aligned = {{(C_SW-1){1'b0}}, |w_sig_small};
        end else begin
            w_aligned = {w_shifted[C_SW-1:1], w_shifted[0] | w_lost};
        end

        // Results that bypass the arithmetic path are settled here.
        w_spec     = 1'b1;
        w_spec_res = '0;
        if (w_x_nan || w_y_nan || (w_x_inf && w_y_inf && (w_x_sign != w_y_sign))) begin
            w_spec_res = C_QNAN;
        end else if (w_x_inf) begin
            w_spec_res = {w_x_sign, C_EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_y_inf) begin
            w_spec_res = {w_y_sign, C_EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_x_zero && w_y_zero) begin
            w_spec_res = {w_x_sign & w_y_sign, {(C_W-1){1'b0}}};
        end else begin
            w_spec = 1'b0;
        end
    end

    logic                r_v1, r_spec1, r_sign1, r_esub1;
    logic [C_W-1:0]      r_spec_res1;
    logic [EXP_W-1:0]    r_exp1;
    logic [C_SW-1:0]     r_siga1, r_sigb1;
    logic [TAG_W-1:0]    r_tag1;

    // Stage 2: add / normalise
    logic [C_SW:0]       w_sum;
    logic [C_LZW-1:0]    w_lz;
    logic [C_SW-1:0]     w_norm;
    logic [C_EW-1:0]     w_exp2;
    logic                w_zero2;

    always_comb begin
        w_sum   = r_esub1 ? ({1'b0, r_siga1} - {1'b0, r_sigb1})
                          : ({1'b0, r_siga1} + {1'b0, r_sigb1});
        w_lz    = lzc(w_sum[C_SW-1:0]);
        w_zero2 = (w_sum == '0);
        if (w_sum[C_SW]) begin
            w_norm = {w_sum[C_SW:2], w_sum[1] | w_sum[0]};
            w_exp2 = {{(C_EW-EXP_W){1'b0}}, r_exp1} + C_EW'(1);
        end else begin
            w_norm = w_sum[C_SW-1:0] << w_lz;
            w_exp2 = {{(C_EW-EXP_W){1'b0}}, r_exp1} - C_EW'(w_lz);
        end
    end

    logic                r_v2, r_spec2, r_sign2, r_zero2;
    logic [C_W-1:0]      r_spec_res2;
    logic [C_EW-1:0]     r_exp2;
    logic [C_SW-1:0]     r_sig2;
    logic [TAG_W-1:0]    r_tag2;

    // Stage 3: round to nearest even / pack
    logic [MAN_W:0]      w_mant;
    logic [2:0]          w_grs;
    logic                w_rnd_up, w_ovf, w_unf;
    logic [MAN_W+1:0]    w_mant_r;
    logic [C_EW-1:0]     w_exp_r;
    logic [MAN_W-1:0]    w_frac_r;
    logic [C_W-1:0]      w_res;

    always_comb begin
        w_mant   = r_sig2[C_SW-1:3];
        w_grs    = r_sig2[2:0];
        w_rnd_up = w_grs[2] & (w_grs[1] | w_grs[0] | w_mant[0]);
        w_mant_r = {1'b0, w_mant} + {{(MAN_W+1){1'b0}}, w_rnd_up};
        w_exp_r  = r_exp2 + {{(C_EW-1){1'b0}}, w_mant_r[MAN_W+1]};
        w_frac_r = w_mant_r[MAN_W+1] ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];
        w_ovf    = !w_exp_r[C_EW-1] && (w_exp_r >= C_EXP_MAX);
        w_unf    = w_exp_r[C_EW-1] || (w_exp_r == '0);
        w_res    = {r_sign2, w_exp_r[EXP_W-1:0], w_frac_r};
        if (r_spec2) begin
            w_res = r_spec_res2;
        end else if (r_zero2) begin
            w_res = '0;
        end else if (w_ovf) begin
            w_res = {r_sign2, C_EXP_ONES, {MAN_W{1'b0}}};
        end else if (w_unf) begin
            w_res = {r_sign2, {(C_W-1){1'b0}}};
        end
    end

    // Datapath registers carry no reset; only valid bits and outputs do.
    always_ff @(posedge Clock) begin
        if (!w_stall) begin
            r_op1       <= Op1;
            r_op2       <= Op2;
            r_sub0      <= Sub;
            r_tag0      <= InTag;
            r_spec1     <= w_spec;
            r_spec_res1 <= w_spec_res;
            r_sign1     <= w_big_sign;
            r_esub1     <= w_big_sign ^ w_small_sign;
            r_exp1      <= w_big_exp;
            r_siga1     <= w_sig_big;
            r_sigb1     <= w_aligned;
            r_tag1      <= r_tag0;
            r_spec2     <= r_spec1;
            r_spec_res2 <= r_spec_res1;
            r_sign2     <= r_sign1;
            r_zero2     <= w_zero2;
            r_exp2      <= w_exp2;
            r_sig2      <= w_norm;
            r_tag2      <= r_tag1;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_v0        <= 1'b0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            ResultValid <= 1'b0;
            Result      <= '0;
            ResultTag   <= '0;
        end else if (!w_stall) begin
            r_v0        <= InputValid;
            r_v1        <= r_v0;
            r_v2        <= r_v1;
            ResultValid <= r_v2;
            Result      <= w_res;
            ResultTag   <= r_tag2;
        end
    end

`ifdef FLOAT_ADDSUB_FLAGS_EN
    logic [3:0] w_flags;

    // A special result is a NaN only when the operation was invalid.
    always_comb begin
        w_flags = '0;
        if (r_spec2) begin
            w_flags[3] = (&r_spec_res2[C_W-2:MAN_W]) && (|r_spec_res2[MAN_W-1:0]);
        end else if (!r_zero2) begin
            w_flags[2] = w_ovf;
            w_flags[1] = !w_ovf && w_unf;
            w_flags[0] = (|w_grs) || w_ovf;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Flags <= '0;
        end else if (!w_stall) begin
            Flags <= w_flags;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_float_addsub_pipe.sv
// ============================================================================
// Module   : tb_float_addsub_pipe
// Purpose  : Scoreboard testbench for float_addsub_pipe (binary32).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_float_addsub_pipe;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  tag;
        logic [3:0]  flg;
    } exp_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] Op1, Op2;
    logic        Sub;
    logic [3:0]  InTag;
    logic        InputValid;
    logic        InputReady;
    logic [31:0] Result;
    logic [3:0]  ResultTag;
    logic        ResultValid;
    logic        ResultReady;
`ifdef FLOAT_ADDSUB_FLAGS_EN
    logic [3:0]  Flags;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[14];

    float_addsub_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Op1        (Op1),
        .Op2        (Op2),
        .Sub        (Sub),
        .InTag      (InTag),
        .InputValid (InputValid),
        .InputReady (InputReady),
        .Result     (Result),
        .ResultTag  (ResultTag),
        .ResultValid(ResultValid),
`ifdef FLOAT_ADDSUB_FLAGS_EN
        .Flags      (Flags),
`endif
        .ResultReady(ResultReady)
    );

    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, expv);
        end
    endtask

    // Present one operation and hold it until accepted; push its expectation.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [3:0] t, input logic [31:0] r, input logic [3:0] f);
        int n;
        @(negedge Clock);
        Op1 = a; Op2 = b; Sub = s; InTag = t; InputValid = 1'b1;
        #1;
        n = 0;
        while (!InputReady && n < 50) begin
            @(negedge Clock);
            #1;
            n++;
        end
        if (!InputReady) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout tag=%0d got=stalled expected=accepted", t);
        end else begin
            sb.push_back('{r, t, f});
        end
        @(posedge Clock);
        #1 InputValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge Clock);
            n++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        repeat (2) @(negedge Clock);
    endtask

    // Monitor: compares every output transfer against the scoreboard head.
    initial begin
        exp_t e;
        logic ok;
        forever begin
            @(negedge Clock);
            #2;
            if (!Reset && ResultValid && ResultReady) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got=%h tag=%0d expected=none", Result, ResultTag);
                end else begin
                    e  = sb.pop_front();
                    ok = (Result === e.res) && (ResultTag === e.tag);
`ifdef FLOAT_ADDSUB_FLAGS_EN
                    ok = ok && (Flags === e.flg);
                    if (!ok) begin
                        errors++;
                        $display("FAIL result got=%h/tag%0d/flags%b expected=%h/tag%0d/flags%b",
                                 Result, ResultTag, Flags, e.res, e.tag, e.flg);
                    end
`else
                    if (!ok) begin
                        errors++;
                        $display("FAIL result got=%h/tag%0d expected=%h/tag%0d",
                                 Result, ResultTag, e.res, e.tag);
                    end
`endif
                end
            end
        end
    end

    initial begin
        vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000};
        vecs[1]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000};
        vecs[2]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001};
        vecs[3]  = '{32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002, 4'b0001};
        vecs[4]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000};
        vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101};
        vecs[6]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000};
        vecs[7]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000};
        vecs[8]  = '{32'h3FC00000, 32'h40200000, 1'b1, 32'hBF800000, 4'b0000};
        vecs[9]  = '{32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000};
        vecs[10] = '{32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0010};
        vecs[11] = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'b0000};
        vecs[12] = '{32'hBF800000, 32'hBF800000, 1'b1, 32'h00000000, 4'b0000};
        vecs[13] = '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000};

        Reset = 1'b1; InputValid = 1'b0; Op1 = '0; Op2 = '0; Sub = 1'b0; InTag = '0;
        ResultReady = 1'b1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("rst_valid", 32'(ResultValid), 32'd0);
        check("rst_result", Result, 32'd0);
        check("rst_tag", 32'(ResultTag), 32'd0);
        check("rst_inready", 32'(InputReady), 32'd1);
`ifdef FLOAT_ADDSUB_FLAGS_EN
        check("rst_flags", 32'(Flags), 32'd0);
`endif

        // Basic add with exact latency
        issue(32'h40900000, 32'h40200000, 1'b0, 4'd3, 32'h40E00000, 4'b0000);
        for (int j = 1; j <= 3; j++) begin
            @(posedge Clock);
            #1;
            check("latency_valid", 32'(ResultValid), (j == 3) ? 32'd1 : 32'd0);
        end
        drain();

        // Directed vectors, back-to-back
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].s, 4'(i), vecs[i].r, vecs[i].f);
        end
        drain();

        // Backpressure: 6 ops, ResultReady low for 4 cycles at first result
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    issue(32'h3F800000 + (32'(i) << 23), 32'h3F800000 + (32'(i) << 23), 1'b0,
                          4'(i), 32'h40000000 + (32'(i) << 23), 4'b0000);
                end
            end
            begin : bp_ctrl
                int n;
                logic [31:0] held;
                n = 0;
                while (!ResultValid && n < 30) begin
                    @(negedge Clock);
                    n++;
                end
                check("bp_first_result", 32'(ResultValid), 32'd1);
                ResultReady = 1'b0;
                #1;
                held = Result;
                for (int j = 0; j < 4; j++) begin
                    if (j > 0) begin
                        @(negedge Clock);
                        #1;
                        check("bp_hold", Result, held);
                        check("bp_valid_hold", 32'(ResultValid), 32'd1);
                    end
                    check("bp_inready", 32'(InputReady), 32'd0);
                end
                @(negedge Clock);
                ResultReady = 1'b1;
                #1;
                check("bp_inready_rel", 32'(InputReady), 32'd1);
            end
        join
        drain();

        // Reset with three operations in flight
        issue(vecs[2].a, vecs[2].b, vecs[2].s, 4'd10, vecs[2].r, vecs[2].f);
        issue(vecs[3].a, vecs[3].b, vecs[3].s, 4'd11, vecs[3].r, vecs[3].f);
        issue(vecs[9].a, vecs[9].b, vecs[9].s, 4'd12, vecs[9].r, vecs[9].f);
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        sb.delete();
        check("midrst_valid", 32'(ResultValid), 32'd0);
        check("midrst_inready", 32'(InputReady), 32'd1);
        @(negedge Clock);
        Reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(posedge Clock);
            #1;
            check("midrst_no_output", 32'(ResultValid), 32'd0);
        end
        issue(32'h40900000, 32'h40200000, 1'b0, 4'd9, 32'h40E00000, 4'b0000);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
